// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID instruction queue.
// The master side is the fetch/decode environment and the slave side is the queue itself.
interface if_id_queue_if #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
);
  logic                         valid_in_ifq;
  logic [XLEN-1:0]              pc_in_ifq;
  logic [XLEN-1:0]              pc4_in_ifq;
  logic [XLEN-1:0]              instr_in_ifq;
  logic                         halt_in_ifq;
  logic                         flush_in_ifq;
  logic                         ready_in_ifq;
  logic                         stall_out_ifq;
  logic                         valid_out_ifq;
  logic [XLEN-1:0]              pc_out_ifq;
  logic [XLEN-1:0]              pc4_out_ifq;
  logic [XLEN-1:0]              instr_out_ifq;
  logic                         halt_out_ifq;
  logic [$clog2(DEPTH+1)-1:0]   count_out_ifq;

  modport master (
    output valid_in_ifq, pc_in_ifq, pc4_in_ifq, instr_in_ifq, halt_in_ifq,
           flush_in_ifq, ready_in_ifq,
    input  stall_out_ifq, valid_out_ifq, pc_out_ifq, pc4_out_ifq,
           instr_out_ifq, halt_out_ifq, count_out_ifq
  );

  modport slave (
    input  valid_in_ifq, pc_in_ifq, pc4_in_ifq, instr_in_ifq, halt_in_ifq,
           flush_in_ifq, ready_in_ifq,
    output stall_out_ifq, valid_out_ifq, pc_out_ifq, pc4_out_ifq,
           instr_out_ifq, halt_out_ifq, count_out_ifq
  );
endinterface

// File: rtl/if_id_queue.sv
// Circular instruction buffer between fetch and decode, with redirect flush,
// sticky halt blocking and PC-hold back-pressure toward fetch.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic           clk,
  input  logic           rst,
  if_id_queue_if.slave   q
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_STEP = PW'(1);
  localparam logic [CW-1:0] CNT_STEP = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] instr;
    logic            halt;
  } entry_t;

  entry_t          storage [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            halt_seen;

  entry_t          head;
  logic            empty;
  logic            full;
  logic            valid;
  logic            deq;
  logic            enq;

  // A slot freed by a same-cycle dequeue may be refilled even when full.
  always_comb begin
    head  = storage[rd_ptr];
    empty = (count == '0);
    full  = (count == CNT_FULL);
    valid = ~empty & ~q.flush_in_ifq;
    deq   = valid & q.ready_in_ifq;
    enq   = q.valid_in_ifq & ~q.flush_in_ifq & ~halt_seen & (~full | deq);
  end

  assign q.valid_out_ifq = valid;
  assign q.stall_out_ifq = halt_seen | (full & ~deq);
  assign q.pc_out_ifq    = empty ? '0 : head.pc;
  assign q.pc4_out_ifq   = empty ? '0 : head.pc4;
  assign q.instr_out_ifq = empty ? '0 : head.instr;
  assign q.halt_out_ifq  = valid & head.halt;
  assign q.count_out_ifq = count;

  always_ff @(posedge clk) begin
    if (rst || q.flush_in_ifq) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      halt_seen <= 1'b0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PTR_STEP;
      end
      if (deq) begin
        rd_ptr <= rd_ptr + PTR_STEP;
      end
      if (enq && !deq) begin
        count <= count + CNT_STEP;
      end else if (deq && !enq) begin
        count <= count - CNT_STEP;
      end
      if (enq && q.halt_in_ifq) begin
        halt_seen <= 1'b1;
      end
    end
  end

  // Payload storage is intentionally left unreset; empty masks it on the outputs.
  always_ff @(posedge clk) begin
    if (enq && !rst) begin
      storage[wr_ptr] <= '{pc: q.pc_in_ifq, pc4: q.pc4_in_ifq,
                           instr: q.instr_in_ifq, halt: q.halt_in_ifq};
    end
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven check of if_id_queue (DEPTH=2): each vector drives one
// cycle and compares the combinational outputs seen before the next rising edge.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic clk;
  logic rst;
  int   asserts;
  int   failures;

  if_id_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) bus ();

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        r;
    logic        vin;
    logic [31:0] pc;
    logic        halt;
    logic        flush;
    logic        rdy;
    logic        e_stall;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_halt;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic vin, logic [31:0] pc, logic halt,
                              logic flush, logic rdy, logic e_stall, logic e_valid,
                              logic [31:0] e_pc, logic e_halt, logic [1:0] e_cnt);
    vec_t v;
    v.r = r; v.vin = vin; v.pc = pc; v.halt = halt; v.flush = flush; v.rdy = rdy;
    v.e_stall = e_stall; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_halt = e_halt; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Fetch encodes the PC into the instruction word so the payload is traceable.
  function automatic logic [31:0] instrOf(logic [31:0] pc);
    return (pc << 8) | 32'h13;
  endfunction

  task automatic applyStimulus(input logic r, input logic vin, input logic [31:0] pc,
                               input logic halt, input logic flush, input logic rdy);
    @(negedge clk);
    rst                  = r;
    bus.valid_in_ifq     = vin;
    bus.pc_in_ifq        = pc;
    bus.pc4_in_ifq       = pc + 32'd4;
    bus.instr_in_ifq     = instrOf(pc);
    bus.halt_in_ifq      = halt;
    bus.flush_in_ifq     = flush;
    bus.ready_in_ifq     = rdy;
    #1;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] exp);
    asserts++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s.%s: got %h expected %h", name, field, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_stall, input logic e_valid,
                             input logic [31:0] e_pc, input logic e_halt,
                             input logic [1:0] e_cnt);
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
    e_pc4   = (e_cnt != 2'd0) ? e_pc + 32'd4 : 32'd0;
    e_instr = (e_cnt != 2'd0) ? instrOf(e_pc) : 32'd0;
    cmp(name, "stall", {31'd0, bus.stall_out_ifq}, {31'd0, e_stall});
    cmp(name, "valid", {31'd0, bus.valid_out_ifq}, {31'd0, e_valid});
    cmp(name, "pc",    bus.pc_out_ifq, e_pc);
    cmp(name, "pc4",   bus.pc4_out_ifq, e_pc4);
    cmp(name, "instr", bus.instr_out_ifq, e_instr);
    cmp(name, "halt",  {31'd0, bus.halt_out_ifq}, {31'd0, e_halt});
    cmp(name, "count", {30'd0, bus.count_out_ifq}, {30'd0, e_cnt});
  endtask

  initial begin
    asserts  = 0;
    failures = 0;

    //                r  vin pc      hlt fl rdy | stall val e_pc    e_hlt cnt
    // fill / drain
    vecs.push_back(mk(0, 1, 32'h00, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    vecs.push_back(mk(0, 1, 32'h04, 0, 0, 0,   0, 1, 32'h00, 0, 2'd1));
    vecs.push_back(mk(0, 1, 32'h08, 0, 0, 0,   1, 1, 32'h00, 0, 2'd2));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   0, 1, 32'h00, 0, 2'd2));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   0, 1, 32'h04, 0, 2'd1));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    // full with simultaneous enqueue/dequeue
    vecs.push_back(mk(0, 1, 32'h18, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    vecs.push_back(mk(0, 1, 32'h1c, 0, 0, 0,   0, 1, 32'h18, 0, 2'd1));
    vecs.push_back(mk(0, 1, 32'h20, 0, 0, 1,   0, 1, 32'h18, 0, 2'd2));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   0, 1, 32'h1c, 0, 2'd2));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   0, 1, 32'h20, 0, 2'd1));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    // flush drops queued and same-cycle entries
    vecs.push_back(mk(0, 1, 32'h40, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    vecs.push_back(mk(0, 1, 32'h44, 0, 0, 0,   0, 1, 32'h40, 0, 2'd1));
    vecs.push_back(mk(0, 1, 32'h48, 0, 1, 1,   1, 0, 32'h40, 0, 2'd2));
    vecs.push_back(mk(0, 1, 32'h80, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   0, 1, 32'h80, 0, 2'd1));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 1,   0, 1, 32'h80, 0, 2'd1));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    // halt blocks further fetches until a flush
    vecs.push_back(mk(0, 1, 32'h10, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    vecs.push_back(mk(0, 1, 32'h16, 1, 0, 0,   0, 1, 32'h10, 0, 2'd1));
    vecs.push_back(mk(0, 1, 32'h1a, 0, 0, 0,   1, 1, 32'h10, 0, 2'd2));
    vecs.push_back(mk(0, 1, 32'h1a, 0, 0, 1,   1, 1, 32'h10, 0, 2'd2));
    vecs.push_back(mk(0, 1, 32'h1a, 0, 0, 0,   1, 1, 32'h16, 1, 2'd1));
    vecs.push_back(mk(0, 1, 32'h1a, 0, 0, 0,   1, 1, 32'h16, 1, 2'd1));
    vecs.push_back(mk(0, 0, 32'h00, 0, 1, 0,   1, 0, 32'h16, 0, 2'd1));
    vecs.push_back(mk(0, 1, 32'h60, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   0, 1, 32'h60, 0, 2'd1));
    // reset mid-operation with halt_seen set, then reset+flush together
    vecs.push_back(mk(0, 1, 32'h64, 1, 0, 0,   0, 1, 32'h60, 0, 2'd1));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   1, 1, 32'h60, 0, 2'd2));
    vecs.push_back(mk(1, 0, 32'h00, 0, 0, 0,   1, 1, 32'h60, 0, 2'd2));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));
    vecs.push_back(mk(1, 1, 32'h70, 0, 1, 0,   0, 0, 32'h00, 0, 2'd0));
    vecs.push_back(mk(0, 0, 32'h00, 0, 0, 0,   0, 0, 32'h00, 0, 2'd0));

    applyStimulus(1, 0, 32'h0, 0, 0, 0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].r, vecs[i].vin, vecs[i].pc, vecs[i].halt,
                    vecs[i].flush, vecs[i].rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_valid,
                  vecs[i].e_pc, vecs[i].e_halt, vecs[i].e_cnt);
    end

    // streaming: one entry per cycle after a single cycle of latency
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 32'h100 + 32'(4 * k), 0, 0, 1);
      if (k == 0)
        checkOutput("stream0", 0, 0, 32'h0, 0, 2'd0);
      else
        checkOutput($sformatf("stream%0d", k), 0, 1, 32'h100 + 32'(4 * (k - 1)), 0, 2'd1);
    end
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    checkOutput("stream_tail", 0, 1, 32'h124, 0, 2'd1);
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    checkOutput("stream_empty", 0, 0, 32'h0, 0, 2'd0);

    // pointer wrap: keep the queue full while streaming through it
    applyStimulus(0, 1, 32'h200, 0, 0, 0);
    checkOutput("wrap0", 0, 0, 32'h0, 0, 2'd0);
    applyStimulus(0, 1, 32'h204, 0, 0, 0);
    checkOutput("wrap1", 0, 1, 32'h200, 0, 2'd1);
    for (int j = 2; j < 8; j++) begin
      applyStimulus(0, 1, 32'h200 + 32'(4 * j), 0, 0, 1);
      checkOutput($sformatf("wrap%0d", j), 0, 1, 32'h200 + 32'(4 * (j - 2)), 0, 2'd2);
    end
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    checkOutput("wrap_drain0", 0, 1, 32'h218, 0, 2'd2);
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    checkOutput("wrap_drain1", 0, 1, 32'h21c, 0, 2'd1);
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    checkOutput("wrap_empty", 0, 0, 32'h0, 0, 2'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end
endmodule
